// File: rtl/sr_run_ctrl_pkg.sv
// Shared opcode and state encodings for the sr_cpu run/debug sequencer.
package sr_run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } run_state_e;

   typedef enum logic [2:0] {
      CMD_HALT    = 3'b000,
      CMD_RUN     = 3'b001,
      CMD_STEP    = 3'b010,
      CMD_SET_BP  = 3'b011,
      CMD_CLR_BP  = 3'b100,
      CMD_CLR_CNT = 3'b101
   } run_cmd_e;

endpackage

// File: rtl/sr_step_counter.sv
// Down-counter for STEP sequences: load a count, decrement per retired instruction.
module sr_step_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             is_one
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt    = cnt_q;
   assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sr_run_ctrl.sv
// Run/debug sequencer for sr_cpu: produces one cpuEn per cycle from host commands,
// a single PC breakpoint, step-N sequences and an out-of-band halt request.
module sr_run_ctrl
   import sr_run_ctrl_pkg::*;
#(
   parameter bit RUN_ON_RESET = 1'b1,
   parameter int CNT_W        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [2:0]  cmdOp,
   input  logic [31:0] cmdArg,
   input  logic        haltReq,
   input  logic [31:0] pc,
   output logic        cpuEn,
   output logic        halted,
   output logic        bpHit,
   output logic        stepDone,
   output logic        cmdErr,
   output logic [31:0] retiredCnt,
   output run_state_e  dbg_state
);

   // Command handshake: a command transfers in any cycle where cmdValid & cmdReady;
   // cmdReady is a pure function of state and never depends on cmdValid.

   localparam run_state_e RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

   run_state_e  state_q, state_d;
   logic        bp_en_q, bp_en_d;
   logic [31:0] bp_addr_q, bp_addr_d;
   logic        skip_q, skip_d;
   logic        bp_hit_q, bp_hit_d;
   logic        step_done_q, step_done_d;
   logic        cmd_err_q, cmd_err_d;
   logic [31:0] ret_cnt_q, ret_cnt_d;

   logic             cnt_load;
   logic             cnt_dec;
   logic [CNT_W-1:0] step_cnt;
   logic             step_is_one;
   logic             fire;
   logic             active;
   logic             bp_match;
   logic [CNT_W-1:0] step_arg;

   assign step_arg = cmdArg[CNT_W-1:0];
   assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign bp_match = bp_en_q && (pc == bp_addr_q) && !skip_q;
   assign cpuEn    = active && !haltReq && !bp_match;
   assign cmdReady = (state_q != ST_STEP);
   assign fire     = cmdValid && cmdReady;

   sr_step_counter #(.CNT_W(CNT_W)) u_step_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (step_arg),
      .dec      (cnt_dec),
      .cnt      (step_cnt),
      .is_one   (step_is_one)
   );

   always_comb begin
      state_d     = state_q;
      bp_en_d     = bp_en_q;
      bp_addr_d   = bp_addr_q;
      skip_d      = skip_q;
      bp_hit_d    = bp_hit_q;
      step_done_d = 1'b0;
      cmd_err_d   = 1'b0;
      ret_cnt_d   = ret_cnt_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;

      if (cpuEn) begin
         skip_d    = 1'b0;
         ret_cnt_d = ret_cnt_q + 32'd1;
      end
      if ((state_q == ST_STEP) && cpuEn) begin
         cnt_dec = 1'b1;
      end

      if (fire) begin
         case (run_cmd_e'(cmdOp))
            CMD_HALT: begin
               if (state_q == ST_RUN) state_d = ST_HALT;
            end
            CMD_RUN: begin
               if ((state_q == ST_HALT) && !haltReq) begin
                  state_d  = ST_RUN;
                  skip_d   = 1'b1;
                  bp_hit_d = 1'b0;
               end
            end
            CMD_STEP: begin
               if (state_q == ST_RUN) begin
                  cmd_err_d = 1'b1;
               end else if (!haltReq) begin
                  skip_d   = 1'b1;
                  bp_hit_d = 1'b0;
                  if (step_arg != '0) begin
                     state_d  = ST_STEP;
                     cnt_load = 1'b1;
                  end else begin
                     step_done_d = 1'b1;
                  end
               end
            end
            CMD_SET_BP: begin
               bp_addr_d = cmdArg;
               bp_en_d   = 1'b1;
            end
            CMD_CLR_BP:  bp_en_d = 1'b0;
            // A retirement in the clearing cycle is counted after the clear.
            CMD_CLR_CNT: ret_cnt_d = cpuEn ? 32'd1 : 32'd0;
            default:     cmd_err_d = 1'b1;
         endcase
      end

      if ((state_q == ST_STEP) && cpuEn && step_is_one) begin
         state_d     = ST_HALT;
         step_done_d = 1'b1;
      end

      if (active && !haltReq && bp_match) begin
         state_d  = ST_HALT;
         bp_hit_d = 1'b1;
      end

      if (haltReq) begin
         state_d = ST_HALT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_STATE;
         bp_en_q     <= 1'b0;
         bp_addr_q   <= 32'd0;
         skip_q      <= 1'b0;
         bp_hit_q    <= 1'b0;
         step_done_q <= 1'b0;
         cmd_err_q   <= 1'b0;
         ret_cnt_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         bp_en_q     <= bp_en_d;
         bp_addr_q   <= bp_addr_d;
         skip_q      <= skip_d;
         bp_hit_q    <= bp_hit_d;
         step_done_q <= step_done_d;
         cmd_err_q   <= cmd_err_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   assign halted     = (state_q == ST_HALT);
   assign bpHit      = bp_hit_q;
   assign stepDone   = step_done_q;
   assign cmdErr     = cmd_err_q;
   assign retiredCnt = ret_cnt_q;
   assign dbg_state  = state_q;

   logic unused_cnt;
   assign unused_cnt = ^step_cnt;

endmodule

// File: tb/tb_sr_run_ctrl.sv
// Self-checking bench for sr_run_ctrl: a scripted command table plus hand-written
// sequences for halt request, breakpoint resume and asynchronous reset.
module tb_sr_run_ctrl;
   import sr_run_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmdValid = 1'b0;
   logic        cmdReady;
   logic [2:0]  cmdOp = 3'd0;
   logic [31:0] cmdArg = 32'd0;
   logic        haltReq = 1'b0;
   logic [31:0] pc = 32'd0;
   logic        cpuEn;
   logic        halted;
   logic        bpHit;
   logic        stepDone;
   logic        cmdErr;
   logic [31:0] retiredCnt;
   run_state_e  dbg_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sr_run_ctrl #(.RUN_ON_RESET(1'b1), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmdValid   (cmdValid),
      .cmdReady   (cmdReady),
      .cmdOp      (cmdOp),
      .cmdArg     (cmdArg),
      .haltReq    (haltReq),
      .pc         (pc),
      .cpuEn      (cpuEn),
      .halted     (halted),
      .bpHit      (bpHit),
      .stepDone   (stepDone),
      .cmdErr     (cmdErr),
      .retiredCnt (retiredCnt),
      .dbg_state  (dbg_state)
   );

   typedef struct {
      logic        vld;
      logic [2:0]  op;
      logic [31:0] arg;
      logic [31:0] pcv;
      logic [37:0] exp;
   } vec_t;

   vec_t vecs[$];
   logic [37:0] exp_q[$];

   localparam logic [2:0] OP_HALT = 3'b000, OP_RUN = 3'b001, OP_STEP = 3'b010,
                          OP_SETBP = 3'b011, OP_CLRBP = 3'b100, OP_CLRCNT = 3'b101,
                          OP_BAD = 3'b111;

   // exp packing: {en, rdy, halted, bp_hit, step_done, cmd_err, retired[31:0]}
   task automatic add(input logic v, input logic [2:0] op, input logic [31:0] arg,
                      input logic [31:0] p, input logic en, input logic rdy, input logic hl,
                      input logic bh, input logic sd, input logic er, input logic [31:0] cnt);
      vec_t r;
      r.vld = v; r.op = op; r.arg = arg; r.pcv = p;
      r.exp = {en, rdy, hl, bh, sd, er, cnt};
      vecs.push_back(r);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [2:0] op, input logic [31:0] arg,
                      input logic h, input logic [31:0] p);
      cmdValid = v; cmdOp = op; cmdArg = arg; haltReq = h; pc = p;
      @(negedge clk);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [37:0] e;

      // Test table: RUN_ON_RESET=1, pc stream, breakpoint, STEP 3, STEP 0, errors, counter clear.
      add(0, OP_HALT,  0,        32'h00, 1,1,0,0,0,0, 0);
      add(0, OP_HALT,  0,        32'h04, 1,1,0,0,0,0, 1);
      add(0, OP_HALT,  0,        32'h08, 1,1,0,0,0,0, 2);
      add(1, OP_SETBP, 32'h10,   32'h0C, 1,1,0,0,0,0, 3);
      add(0, OP_HALT,  0,        32'h10, 0,1,0,0,0,0, 4);
      add(0, OP_HALT,  0,        32'h10, 0,1,1,1,0,0, 4);
      add(1, OP_STEP,  3,        32'h10, 0,1,1,1,0,0, 4);
      add(0, OP_HALT,  0,        32'h10, 1,0,0,0,0,0, 4);
      add(0, OP_HALT,  0,        32'h14, 1,0,0,0,0,0, 5);
      add(0, OP_HALT,  0,        32'h18, 1,0,0,0,0,0, 6);
      add(0, OP_HALT,  0,        32'h1C, 0,1,1,0,1,0, 7);
      add(1, OP_STEP,  0,        32'h1C, 0,1,1,0,0,0, 7);
      add(0, OP_HALT,  0,        32'h1C, 0,1,1,0,1,0, 7);
      add(0, OP_HALT,  0,        32'h1C, 0,1,1,0,0,0, 7);
      add(1, OP_RUN,   0,        32'h1C, 0,1,1,0,0,0, 7);
      add(0, OP_HALT,  0,        32'h1C, 1,1,0,0,0,0, 7);
      add(1, OP_BAD,   0,        32'h20, 1,1,0,0,0,0, 8);
      add(0, OP_HALT,  0,        32'h24, 1,1,0,0,0,1, 9);
      add(0, OP_HALT,  0,        32'h28, 1,1,0,0,0,0, 10);
      add(1, OP_STEP,  5,        32'h2C, 1,1,0,0,0,0, 11);
      add(0, OP_HALT,  0,        32'h30, 1,1,0,0,0,1, 12);
      add(1, OP_CLRCNT,0,        32'h34, 1,1,0,0,0,0, 13);
      add(0, OP_HALT,  0,        32'h38, 1,1,0,0,0,0, 1);
      add(1, OP_HALT,  0,        32'h3C, 1,1,0,0,0,0, 2);
      add(0, OP_HALT,  0,        32'h40, 0,1,1,0,0,0, 3);
      add(1, OP_CLRBP, 0,        32'h40, 0,1,1,0,0,0, 3);
      add(1, OP_CLRCNT,0,        32'h40, 0,1,1,0,0,0, 3);
      add(0, OP_HALT,  0,        32'h40, 0,1,1,0,0,0, 0);

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cnt", retiredCnt, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_bphit", {31'd0, bpHit}, 32'd0);
      check("rst_flags", {30'd0, stepDone, cmdErr}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[i]) begin
         cmdValid = vecs[i].vld; cmdOp = vecs[i].op; cmdArg = vecs[i].arg;
         haltReq = 1'b0; pc = vecs[i].pcv;
         exp_q.push_back(vecs[i].exp);
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("v%0d_en", i),     {31'd0, cpuEn},    {31'd0, e[37]});
         check($sformatf("v%0d_rdy", i),    {31'd0, cmdReady}, {31'd0, e[36]});
         check($sformatf("v%0d_halted", i), {31'd0, halted},   {31'd0, e[35]});
         check($sformatf("v%0d_bphit", i),  {31'd0, bpHit},    {31'd0, e[34]});
         check($sformatf("v%0d_sdone", i),  {31'd0, stepDone}, {31'd0, e[33]});
         check($sformatf("v%0d_err", i),    {31'd0, cmdErr},   {31'd0, e[32]});
         check($sformatf("v%0d_cnt", i),    retiredCnt,        e[31:0]);
         nxt();
      end

      // STEP 100 aborted by haltReq after 5 retirements.
      drv(1, OP_SETBP, 32'h100, 0, 32'h40); nxt();
      drv(1, OP_STEP, 32'd100, 0, 32'h40); nxt();
      for (int k = 0; k < 5; k++) begin
         drv(0, OP_HALT, 0, 0, 32'h40 + 32'(4 * k));
         check($sformatf("hs_en%0d", k), {31'd0, cpuEn}, 32'd1);
         nxt();
      end
      drv(0, OP_HALT, 0, 1, 32'h54);
      check("hs_req_en", {31'd0, cpuEn}, 32'd0);
      check("hs_req_rdy", {31'd0, cmdReady}, 32'd0);
      nxt();
      drv(0, OP_HALT, 0, 0, 32'h54);
      check("hs_halted", {31'd0, halted}, 32'd1);
      check("hs_rdy", {31'd0, cmdReady}, 32'd1);
      check("hs_sdone", {31'd0, stepDone}, 32'd0);
      check("hs_cnt", retiredCnt, 32'd5);
      nxt();
      drv(0, OP_HALT, 0, 0, 32'h54);
      check("hs_sdone2", {31'd0, stepDone}, 32'd0);
      nxt();

      // RUN resumed at the breakpoint address executes once, then traps on return.
      drv(1, OP_RUN, 0, 0, 32'h100);
      check("bp_acc_halted", {31'd0, halted}, 32'd1);
      nxt();
      drv(0, OP_HALT, 0, 0, 32'h100);
      check("bp_skip_en", {31'd0, cpuEn}, 32'd1);
      nxt();
      drv(0, OP_HALT, 0, 0, 32'h104);
      check("bp_next_en", {31'd0, cpuEn}, 32'd1);
      nxt();
      drv(0, OP_HALT, 0, 0, 32'h100);
      check("bp_trap_en", {31'd0, cpuEn}, 32'd0);
      nxt();
      drv(0, OP_HALT, 0, 0, 32'h100);
      check("bp_halted", {31'd0, halted}, 32'd1);
      check("bp_hit", {31'd0, bpHit}, 32'd1);
      check("bp_cnt", retiredCnt, 32'd7);
      nxt();

      // Asynchronous reset in the middle of a STEP sequence.
      drv(1, OP_STEP, 32'd10, 0, 32'h100); nxt();
      drv(0, OP_HALT, 0, 0, 32'h100);
      check("rs_en0", {31'd0, cpuEn}, 32'd1);
      nxt();
      drv(0, OP_HALT, 0, 0, 32'h104); nxt();
      rst_n = 1'b0;
      #1;
      check("rs_cnt", retiredCnt, 32'd0);
      check("rs_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
      check("rs_halted", {31'd0, halted}, 32'd0);
      check("rs_rdy", {31'd0, cmdReady}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drv(0, OP_HALT, 0, 0, 32'h0);
      check("rs_sdone", {31'd0, stepDone}, 32'd0);
      check("rs_run_en", {31'd0, cpuEn}, 32'd1);
      check("rs_bphit", {31'd0, bpHit}, 32'd0);
      nxt();
      drv(0, OP_HALT, 0, 0, 32'h10);
      check("rs_cnt1", retiredCnt, 32'd1);
      check("rs_nobp_en", {31'd0, cpuEn}, 32'd1);
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
